// File: rtl/aoi_bist_ctrl.sv
// Self-test sequencer for the 10-input AND-OR-INVERT gate.
// Sweeps all input vectors, or applies one supplied vector, and waits a
// settle interval before sampling Y. Responses are compacted into a
// ones-count and a MISR signature, and a pass flag is registered at the end.
module aoi_bist_ctrl #(
    parameter int              N_IN   = 10,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N_IN-1:0]  vec_in,
    input  logic             abort,
    input  logic [SIG_W-1:0] exp_sig,
    output logic [N_IN-1:0]  aoi_in,
    input  logic             aoi_y,
    output logic             busy,
    output logic             done,
    output logic [N_IN:0]    ones_cnt,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    // The settle counter is kept at least one bit wide so SETTLE=0 still elaborates.
    localparam int            WW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = (SETTLE > 0) ? WW'(SETTLE - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [N_IN-1:0]  aoi_in_q, aoi_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_IN:0]    ones_q, ones_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;

    // Next-state and next-output computation; abort overrides any active state.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        aoi_in_d = aoi_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ones_d   = ones_q;
        sig_d    = sig_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    vec_d   = vec_in;
                    ones_d  = '0;
                    sig_d   = SEED;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                aoi_in_d = mode_q ? vec_q : cnt_q;
                wcnt_d   = WAIT_LOAD;
                state_d  = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (wcnt_q == '0) state_d = S_SAMPLE;
                else              wcnt_d  = wcnt_q - 1'b1;
            end
            S_SAMPLE: begin
                ones_d = ones_q + (N_IN + 1)'(aoi_y);
                sig_d  = {sig_q[SIG_W-2:0], 1'b0}
                       ^ (sig_q[SIG_W-1] ? POLY : '0)
                       ^ {{(SIG_W - 1){1'b0}}, aoi_y};
                // The terminal vector ends the run; the counter never wraps.
                if (mode_q || (&cnt_q)) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_FIN: begin
                done_d   = 1'b1;
                pass_d   = (sig_q == exp_sig);
                busy_d   = 1'b0;
                aoi_in_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort discards any in-flight sample; partial results are held.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            aoi_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            ones_d   = ones_q;
            sig_d    = sig_q;
            pass_d   = pass_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            vec_q    <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            aoi_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ones_q   <= '0;
            sig_q    <= SEED;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            aoi_in_q <= aoi_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ones_q   <= ones_d;
            sig_q    <= sig_d;
            pass_q   <= pass_d;
        end
    end

    assign aoi_in    = aoi_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ones_cnt  = ones_q;
    assign signature = sig_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_aoi_bist_ctrl.sv
// Bench for aoi_bist_ctrl: two instances (SETTLE=1 and SETTLE=0) share the
// stimulus; each gets its own Y derived from its own aoi_in. Expected counts
// and signatures come from a vector-list model of the gate response.
module tb_aoi_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, mode, abort;
    logic [9:0]  vec_in;
    logic [15:0] exp_sig;
    logic [9:0]  aoi1, aoi0;
    logic        y1, y0;
    logic        busy1, busy0, done1, done0, pass1, pass0;
    logic [10:0] ones1, ones0;
    logic [15:0] sig1, sig0;

    int   total = 0;
    int   bad   = 0;
    int   ysel  = 0;
    logic rtab [1024];

    always #5 clk = ~clk;

    aoi_bist_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_in(vec_in),
        .abort(abort), .exp_sig(exp_sig), .aoi_in(aoi1), .aoi_y(y1),
        .busy(busy1), .done(done1), .ones_cnt(ones1), .signature(sig1), .pass(pass1)
    );

    aoi_bist_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_in(vec_in),
        .abort(abort), .exp_sig(exp_sig), .aoi_in(aoi0), .aoi_y(y0),
        .busy(busy0), .done(done0), .ones_cnt(ones0), .signature(sig0), .pass(pass0)
    );

    // Gate stand-in: response selected by ysel.
    always_comb begin
        case (ysel)
            0:       begin y1 = 1'b0;       y0 = 1'b0;       end
            1:       begin y1 = &aoi1;      y0 = &aoi0;      end
            2:       begin y1 = aoi1[0];    y0 = aoi0[0];    end
            3:       begin y1 = 1'b1;       y0 = 1'b1;       end
            default: begin y1 = rtab[aoi1]; y0 = rtab[aoi0]; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic yf(input logic [9:0] v);
        case (ysel)
            0:       return 1'b0;
            1:       return (v == 10'h3FF);
            2:       return v[0];
            3:       return 1'b1;
            default: return rtab[v];
        endcase
    endfunction

    // Response of the first nvec vectors of a run, compacted.
    task automatic model(input logic m, input logic [9:0] v, input int nvec,
                         output int ones, output logic [15:0] sig);
        ones = 0;
        sig  = 16'h0000;
        for (int i = 0; i < nvec; i++) begin
            logic [9:0] x;
            logic       y;
            x = m ? v : 10'(i);
            y = yf(x);
            ones += int'(y);
            sig = (sig << 1) ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, y};
        end
    endtask

    // Leaves the bench at the falling edge right after the start edge.
    task automatic do_start(input logic m, input logic [9:0] v, input logic ab);
        @(negedge clk);
        mode = m; vec_in = v; start = 1'b1; abort = ab;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int e1, input int e0,
                             input logic m, input logic [9:0] v);
        int d1 = -1, d0 = -1, c1 = 0, c0 = 0, err = 0;
        for (int n = 1; n <= e1 + 5; n++) begin
            @(negedge clk);
            if (done1) begin c1++; if (d1 < 0) d1 = n; end
            if (done0) begin c0++; if (d0 < 0) d0 = n; end
            if (n < e1 && aoi1 !== (m ? v : 10'((n - 1) / 3))) err++;
            if (n < e0 && aoi0 !== (m ? v : 10'((n - 1) / 2))) err++;
            if (n < e1 && busy1 !== 1'b1) err++;
        end
        chk({tag, "_done_at1"}, d1, e1);
        chk({tag, "_done_at0"}, d0, e0);
        chk({tag, "_done_len"}, c1 + c0, 2);
        chk({tag, "_steps"}, err, 0);
        chk({tag, "_idle"}, {busy1, busy0}, 0);
    endtask

    task automatic run_chk(input string tag, input logic m, input logic [9:0] v,
                           input logic ab, input bit match);
        int          oe;
        logic [15:0] se;
        model(m, v, m ? 1 : 1024, oe, se);
        exp_sig = match ? se : (se ^ 16'h0101);
        do_start(m, v, ab);
        wait_done(tag, m ? 4 : 3073, m ? 3 : 2049, m, v);
        chk({tag, "_ones1"}, ones1, oe);
        chk({tag, "_ones0"}, ones0, oe);
        chk({tag, "_sig1"}, sig1, se);
        chk({tag, "_sig0"}, sig0, se);
        chk({tag, "_pass1"}, pass1, match);
        chk({tag, "_pass0"}, pass0, match);
    endtask

    initial begin
        int          oe1, oe0, err, dseen;
        logic [15:0] se1, se0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        vec_in = '0; exp_sig = '0;
        for (int i = 0; i < 1024; i++) rtab[i] = 1'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {busy1, busy0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_aoi", {aoi1, aoi0}, 0);
        chk("rst_ones", {ones1, ones0}, 0);
        chk("rst_sig", {sig1, sig0}, 0);
        chk("rst_pass", {pass1, pass0}, 0);

        ysel = 0; run_chk("tie0", 1'b0, 10'h0, 1'b0, 1'b1);
        ysel = 1; run_chk("and", 1'b0, 10'h0, 1'b0, 1'b1);
        ysel = 2; run_chk("bit0", 1'b0, 10'h0, 1'b0, 1'b0);
        ysel = 3; run_chk("single", 1'b1, 10'h018, 1'b0, 1'b1);
        ysel = 4; run_chk("rand_exh", 1'b0, 10'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            run_chk("rand_single", 1'b1, 10'($urandom), 1'b0, k[0]);

        // Abort mid-sweep, with a start pulse while busy.
        ysel = 2;
        exp_sig = 16'h0000;
        do_start(1'b0, 10'h0, 1'b0);
        err = 0; dseen = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = (n == 50);
            if (done1 || done0) dseen++;
            if (aoi1 !== 10'((n - 1) / 3)) err++;
            if (aoi0 !== 10'((n - 1) / 2)) err++;
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_steps", err, 0);
        chk("abort_busy", {busy1, busy0}, 0);
        chk("abort_aoi", {aoi1, aoi0}, 0);
        repeat (10) begin
            @(negedge clk);
            if (done1 || done0) dseen++;
        end
        chk("abort_nodone", dseen, 0);
        model(1'b0, 10'h0, 33, oe1, se1);
        model(1'b0, 10'h0, 50, oe0, se0);
        chk("abort_ones1", ones1, oe1);
        chk("abort_ones0", ones0, oe0);
        chk("abort_sig1", sig1, se1);
        chk("abort_sig0", sig0, se0);
        chk("abort_pass", {pass1, pass0}, 0);

        // Fresh start, with abort asserted alongside it in IDLE.
        ysel = 4; run_chk("start_abort", 1'b0, 10'h0, 1'b1, 1'b1);

        // Reset in the middle of a sweep.
        ysel = 2;
        do_start(1'b0, 10'h0, 1'b0);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {busy1, busy0}, 0);
        chk("midrst_aoi", {aoi1, aoi0}, 0);
        chk("midrst_ones", {ones1, ones0}, 0);
        chk("midrst_sig", {sig1, sig0}, 0);
        dseen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) dseen++;
        end
        chk("midrst_quiet", dseen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
